io_input_buffer: RTL and testbench

//   Write side of the memory-mapped I/O region. Captures CPU stores into the

---
 rtl/io_pkg.sv | 48 ++++
 rtl/io_input_buffer_if.sv | 12 +
 rtl/io_debounce.sv | 42 ++++
 rtl/io_input_buffer.sv | 75 +++++++
 tb/tb_io_input_buffer.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/io_pkg.sv
// Shared I/O region definitions: page numbers, the decoded store target and
// a byte-lane merge helper. output_mux uses the same page constants.
package io_pkg;

  localparam logic [19:0] IO_LEDR_PAGE = 20'h10000;
  localparam logic [19:0] IO_LEDG_PAGE = 20'h10001;
  localparam logic [19:0] IO_HEXL_PAGE = 20'h10002;
  localparam logic [19:0] IO_HEXH_PAGE = 20'h10003;
  localparam logic [19:0] IO_LCD_PAGE  = 20'h10004;
  localparam logic [19:0] IO_SW_PAGE   = 20'h10010;
  localparam logic [19:0] IO_BTN_PAGE  = 20'h10011;

  localparam int N_OUT_BUF = 5;

  typedef enum logic [2:0] {
    SEL_NONE = 3'd0,
    SEL_LEDR = 3'd1,
    SEL_LEDG = 3'd2,
    SEL_HEXL = 3'd3,
    SEL_HEXH = 3'd4,
    SEL_LCD  = 3'd5
  } io_sel_e;

  // Map a store page to its writable buffer; SW/BTN and unknown pages give SEL_NONE.
  function automatic io_sel_e io_decode(input logic [19:0] page);
    case (page)
      IO_LEDR_PAGE: io_decode = SEL_LEDR;
      IO_LEDG_PAGE: io_decode = SEL_LEDG;
      IO_HEXL_PAGE: io_decode = SEL_HEXL;
      IO_HEXH_PAGE: io_decode = SEL_HEXH;
      IO_LCD_PAGE:  io_decode = SEL_LCD;
      default:      io_decode = SEL_NONE;
    endcase
  endfunction

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int n = 0; n < 4; n++) begin
      if (strb[n]) res[8*n +: 8] = new_val[8*n +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/io_input_buffer_if.sv
// LSU store path into the I/O region. A store is taken on any cycle where
// st_en && io_valid is high; there is no back-pressure, so no ready signal.
interface io_input_buffer_if;
  logic        st_en;
  logic        io_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_strb;

  modport master (output st_en, io_valid, st_addr, st_data, st_strb);
  modport slave  (input  st_en, io_valid, st_addr, st_data, st_strb);
endinterface

// File: rtl/io_debounce.sv
// Two-flop synchroniser followed by a hold-time debouncer for a pin vector.
// A new synced value is accepted only after it has held for DB_CYCLES cycles.
module io_debounce #(
  parameter int W         = 10,
  parameter int DB_CYCLES = 50000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);
  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);

  logic [W-1:0]  s1, s2, stable;
  logic [CW-1:0] cnt;

  // Sync chain, hold counter and accepted value; counter restarts on any movement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1     <= '0;
      s2     <= '0;
      stable <= '0;
      cnt    <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s1 != s2) begin
        cnt <= '0;
      end else if (s2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        stable <= s2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  assign dout = stable;
endmodule

// File: rtl/io_input_buffer.sv
// Write side of the memory-mapped I/O region: byte-lane store capture into the
// LEDR/LEDG/HEXL/HEXH/LCD buffers, plus debounced SW/BTN input buffers.
module io_input_buffer
  import io_pkg::*;
#(
  parameter int SW_W           = 10,
  parameter int BTN_W          = 4,
  parameter int DB_CYCLES      = 50000,
  parameter bit BTN_ACTIVE_LOW = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  io_input_buffer_if.slave      st,
  input  logic [SW_W-1:0]       i_io_sw,
  input  logic [BTN_W-1:0]      i_io_btn,
  output logic [31:0]           b_io_ledr,
  output logic [31:0]           b_io_ledg,
  output logic [31:0]           b_io_hexl,
  output logic [31:0]           b_io_hexh,
  output logic [31:0]           b_io_lcd,
  output logic [31:0]           b_io_sw,
  output logic [31:0]           b_io_btn
);
  io_sel_e               sel;
  logic [N_OUT_BUF-1:0]  wr_hit;
  logic [31:0]           obuf [N_OUT_BUF];
  logic [SW_W-1:0]       sw_db;
  logic [BTN_W-1:0]      btn_in, btn_db;

  // Decode the store into a one-hot write select over the five output buffers.
  always_comb begin
    wr_hit = '0;
    sel    = io_decode(st.st_addr[31:12]);
    if (st.st_en && st.io_valid && sel != SEL_NONE) begin
      wr_hit[32'(sel) - 1] = 1'b1;
    end
  end

  // Output buffers: only strobed lanes of the selected buffer update.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int i = 0; i < N_OUT_BUF; i++) obuf[i] <= '0;
    end else begin
      for (int i = 0; i < N_OUT_BUF; i++) begin
        if (wr_hit[i]) obuf[i] <= byte_merge(obuf[i], st.st_data, st.st_strb);
      end
    end
  end

  assign b_io_ledr = obuf[0];
  assign b_io_ledg = obuf[1];
  assign b_io_hexl = obuf[2];
  assign b_io_hexh = obuf[3];
  assign b_io_lcd  = obuf[4];

  // Buttons become 1 = pressed before sync, so the reset-zero chain is "released".
  assign btn_in = BTN_ACTIVE_LOW ? ~i_io_btn : i_io_btn;

  io_debounce #(.W(SW_W), .DB_CYCLES(DB_CYCLES)) u_sw_db (
    .clk   (i_clk),
    .rst_n (i_reset),
    .din   (i_io_sw),
    .dout  (sw_db)
  );

  io_debounce #(.W(BTN_W), .DB_CYCLES(DB_CYCLES)) u_btn_db (
    .clk   (i_clk),
    .rst_n (i_reset),
    .din   (btn_in),
    .dout  (btn_db)
  );

  assign b_io_sw  = 32'(sw_db);
  assign b_io_btn = 32'(btn_db);
endmodule

// File: tb/tb_io_input_buffer.sv
// Bench for io_input_buffer: directed and random stores checked through an
// expected queue, plus switch/button debounce timing and async reset cases.
module tb_io_input_buffer;
  import io_pkg::*;

  localparam int SW_W  = 10;
  localparam int BTN_W = 4;
  localparam int DB    = 8;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  io_input_buffer_if st_bus ();
  logic [SW_W-1:0]  sw;
  logic [BTN_W-1:0] btn;
  logic [31:0] ledr, ledg, hexl, hexh, lcd, sw_out, btn_out;

  io_input_buffer #(
    .SW_W(SW_W), .BTN_W(BTN_W), .DB_CYCLES(DB), .BTN_ACTIVE_LOW(1'b1)
  ) dut (
    .i_clk     (clk),
    .i_reset   (rst_n),
    .st        (st_bus.slave),
    .i_io_sw   (sw),
    .i_io_btn  (btn),
    .b_io_ledr (ledr),
    .b_io_ledg (ledg),
    .b_io_hexl (hexl),
    .b_io_hexh (hexh),
    .b_io_lcd  (lcd),
    .b_io_sw   (sw_out),
    .b_io_btn  (btn_out)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model [5];
  int store_idx = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] buf_of(input int i);
    case (i)
      0:       buf_of = ledr;
      1:       buf_of = ledg;
      2:       buf_of = hexl;
      3:       buf_of = hexh;
      default: buf_of = lcd;
    endcase
  endfunction

  function automatic int page_idx(input logic [19:0] page);
    case (page)
      20'h10000: page_idx = 0;
      20'h10001: page_idx = 1;
      20'h10002: page_idx = 2;
      20'h10003: page_idx = 3;
      20'h10004: page_idx = 4;
      default:   page_idx = -1;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int n = 0; n < 4; n++) if (s[n]) r[8*n +: 8] = d[8*n +: 8];
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  // Drive one store just after an edge, predict all five buffers, then compare
  // every buffer one edge later.
  task automatic do_store(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic valid);
    int t;
    st_bus.st_en    = 1'b1;
    st_bus.io_valid = valid;
    st_bus.st_addr  = addr;
    st_bus.st_data  = data;
    st_bus.st_strb  = strb;
    t = page_idx(addr[31:12]);
    if (valid && t >= 0) model[t] = merge(model[t], data, strb);
    for (int i = 0; i < 5; i++) exp_q.push_back(model[i]);
    @(posedge clk); #1;
    st_bus.st_en    = 1'b0;
    st_bus.io_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("store%0d_buf%0d", store_idx, i), buf_of(i), exp_q.pop_front());
    end
    store_idx++;
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ledr"}, ledr, 32'h0);
    check({tag, "_ledg"}, ledg, 32'h0);
    check({tag, "_hexl"}, hexl, 32'h0);
    check({tag, "_hexh"}, hexh, 32'h0);
    check({tag, "_lcd"},  lcd,  32'h0);
    check({tag, "_sw"},   sw_out,  32'h0);
    check({tag, "_btn"},  btn_out, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  logic [19:0] pages [8];

  initial begin
    pages[0] = 20'h10000; pages[1] = 20'h10001; pages[2] = 20'h10002;
    pages[3] = 20'h10003; pages[4] = 20'h10004; pages[5] = 20'h10010;
    pages[6] = 20'h10011; pages[7] = 20'h00000;
    for (int i = 0; i < 5; i++) model[i] = 32'h0;
    st_bus.st_en = 1'b0; st_bus.io_valid = 1'b0;
    st_bus.st_addr = '0; st_bus.st_data = '0; st_bus.st_strb = '0;
    sw  = '0;
    btn = 4'hF;

    tick(3);
    check_all_zero("reset");
    rst_n = 1'b1;
    tick(2);

    // Full-word and byte-lane stores.
    do_store(32'h1000_0000, 32'hDEAD_BEEF, 4'hF, 1'b1);
    do_store(32'h1000_2000, 32'hFFFF_FFFF, 4'hF, 1'b1);
    do_store(32'h1000_2004, 32'h1234_5678, 4'b0011, 1'b1);
    check("hexl_lanes", hexl, 32'hFFFF_5678);

    // Read-only page, invalid store, zero strobe.
    do_store(32'h1001_0000, 32'hA5A5_A5A5, 4'hF, 1'b1);
    check("sw_ro", sw_out, 32'h0);
    do_store(32'h1000_4000, 32'h1122_3344, 4'hF, 1'b0);
    check("lcd_invalid", lcd, 32'h0);
    do_store(32'h1000_1000, 32'h55AA_55AA, 4'h0, 1'b1);
    check("ledg_nostrb", ledg, 32'h0);

    // Random stores over writable, read-only and foreign pages.
    for (int k = 0; k < 24; k++) begin
      do_store({pages[$urandom_range(0, 7)], 12'($urandom_range(0, 4095))},
               32'($urandom), 4'($urandom_range(0, 15)),
               ($urandom_range(0, 3) != 0));
    end

    // Switch debounce: steady change accepted between DB and DB+4 edges.
    sw = 10'h3FF;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (k <= 7) check($sformatf("sw_early_e%0d", k), sw_out, 32'h0);
      if (k == 12) check("sw_settled", sw_out, 32'h3FF);
    end

    // Button glitch shorter than DB never propagates.
    btn = 4'hE;
    tick(5);
    btn = 4'hF;
    for (int k = 0; k < 16; k++) begin
      tick(1);
      if (k % 4 == 3) check($sformatf("btn_glitch_%0d", k), btn_out, 32'h0);
    end

    // Async reset mid-run clears every buffer without waiting for an edge.
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_rst");
    for (int i = 0; i < 5; i++) model[i] = 32'h0;
    tick(1);
    rst_n = 1'b1;
    tick(DB + 6);

    // Reset in the middle of a button debounce restarts it from release.
    btn = 4'hB;
    tick(6);
    rst_n = 1'b0;
    #1;
    check("btn_rst_mid", btn_out, 32'h0);
    tick(1);
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (k <= 7) check($sformatf("btn_after_rst_e%0d", k), btn_out, 32'h0);
      if (k == 12) check("btn_settled", btn_out, 32'h4);
    end

    // Stores still work after the reset.
    do_store(32'h1000_3000, 32'hCAFE_F00D, 4'b1100, 1'b1);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
